// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring divider, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |divisor| > |dividend|.
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] rs1_val_i,
   input  logic [XLEN-1:0] rs2_val_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [4:0]      wb_dest_o,
   output logic            wb_write_enable_o,
   output logic [XLEN-1:0] wb_data_o
);

   localparam int unsigned CntW = $clog2(XLEN + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            is_rem_q, is_rem_d;
   logic [4:0]      wb_dest_q, wb_dest_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;

   logic            dvd_neg, dvs_neg;
   logic [XLEN-1:0] dvd_mag, dvs_mag;
   logic [XLEN:0]   shifted, trial;

   always_comb begin
      dvd_neg = ~op_i[0] & rs1_val_i[XLEN-1];
      dvs_neg = ~op_i[0] & rs2_val_i[XLEN-1];
      dvd_mag = dvd_neg ? -rs1_val_i : rs1_val_i;
      dvs_mag = dvs_neg ? -rs2_val_i : rs2_val_i;

      // Shifted partial remainder needs one extra bit before the trial subtract.
      shifted = {rem_q, quo_q[XLEN-1]};
      trial   = shifted - {1'b0, dvsr_q};

      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      wb_dest_d = wb_dest_q;
      wb_data_d = wb_data_q;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               wb_dest_d = rd_i;
               state_d   = StDone;
               if (rs2_val_i == '0) begin
                  wb_data_d = op_i[1] ? rs1_val_i : '1;
               end else if (!op_i[0] && rs1_val_i == MinInt && rs2_val_i == '1) begin
                  wb_data_d = op_i[1] ? '0 : MinInt;
`ifdef DIV_EARLY_OUT_EN
               end else if (dvs_mag > dvd_mag) begin
                  wb_data_d = op_i[1] ? rs1_val_i : '0;
`endif
               end else begin
                  state_d   = StCalc;
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = dvd_mag;
                  dvsr_d    = dvs_mag;
                  neg_quo_d = dvd_neg ^ dvs_neg;
                  neg_rem_d = dvd_neg;
                  is_rem_d  = op_i[1];
               end
            end
         end
         StCalc: begin
            quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
            rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               if (is_rem_q) begin
                  wb_data_d = neg_rem_q ? -rem_d : rem_d;
               end else begin
                  wb_data_d = neg_quo_q ? -quo_d : quo_d;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         wb_dest_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
         wb_dest_q <= wb_dest_d;
         wb_data_q <= wb_data_d;
      end
   end

   always_comb begin
      busy_o            = (state_q != StIdle);
      done_o            = (state_q == StDone);
      wb_write_enable_o = done_o && (wb_dest_q != 5'd0);
      wb_dest_o         = wb_dest_q;
      wb_data_o         = wb_data_q;
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operations against
// a plain-arithmetic reference model.
module tb_div_unit;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [1:0]      op;
   logic [4:0]      rd;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            busy;
   logic            done;
   logic [4:0]      wb_dest;
   logic            wb_we;
   logic [XLEN-1:0] wb_data;

   int tests_run = 0;
   int tests_failed = 0;

   div_unit #(.XLEN(XLEN)) dut (
      .clk               (clk),
      .reset             (reset),
      .start_i           (start),
      .op_i              (op),
      .rd_i              (rd),
      .rs1_val_i         (rs1),
      .rs2_val_i         (rs2),
      .busy_o            (busy),
      .done_o            (done),
      .wb_dest_o         (wb_dest),
      .wb_write_enable_o (wb_we),
      .wb_data_o         (wb_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
      int sa;
      int sb;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (o[0]) return o[1] ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa = $signed(a);
      sb = $signed(b);
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      logic [31:0] ma;
      logic [31:0] mb;
      ma = (!o[0] && a[31]) ? 32'd0 - a : a;
      mb = (!o[0] && b[31]) ? 32'd0 - b : b;
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (mb > ma) return 1;
`endif
      return XLEN + 1;
   endfunction

   // Start one operation, optionally pulse start again before edge T0+glitch_at.
   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input int glitch_at);
      int cyc;
      logic [31:0] exp;
      exp = ref_model(o, a, b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      rs1   = a;
      rs2   = b;
      rd    = r;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < int'(XLEN) + 20) begin
         start = (cyc == glitch_at);
         rs1   = $urandom;
         rs2   = $urandom;
         op    = 2'($urandom);
         rd    = 5'($urandom);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check($sformatf("%s done", name), 32'(done), 32'd1);
      check($sformatf("%s latency", name), 32'(cyc), 32'(exp_latency(o, a, b)));
      check($sformatf("%s data", name), wb_data, exp);
      check($sformatf("%s dest", name), 32'(wb_dest), 32'(r));
      check($sformatf("%s we", name), 32'(wb_we), 32'(r != 5'd0));
      @(negedge clk);
      check($sformatf("%s done pulse", name), 32'(done), 32'd0);
      check($sformatf("%s we pulse", name), 32'(wb_we), 32'd0);
      check($sformatf("%s idle", name), 32'(busy), 32'd0);
      check($sformatf("%s hold", name), wb_data, exp);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'($urandom_range(0, 15));
         1:       return 32'd0;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return 32'($urandom_range(0, 999));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'd0;
      rd    = 5'd0;
      rs1   = '0;
      rs2   = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset we", 32'(wb_we), 32'd0);
      check("reset dest", 32'(wb_dest), 32'd0);
      check("reset data", wb_data, 32'd0);
      reset = 1'b0;

      run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 5'd5, 0);
      run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 5'd5, 0);
      run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
      run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
      run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 0);
      run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 0);
      run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 5'd6, 0);
      run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 5'd7, 0);
      run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
      run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
      run_op("glitch", 2'b01, 32'd1000, 32'd9, 5'd10, 3);
      run_op("rd0", 2'b01, 32'd50, 32'd6, 5'd0, 0);
      run_op("divu 3/10", 2'b01, 32'd3, 32'd10, 5'd11, 0);
      run_op("remu 3/10", 2'b11, 32'd3, 32'd10, 5'd12, 0);

      // Abort mid-operation with reset.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      rs1   = 32'hFFFF_FFF0;
      rs2   = 32'd3;
      rd    = 5'd13;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort we", 32'(wb_we), 32'd0);
      check("abort dest", 32'(wb_dest), 32'd0);
      check("abort data", wb_data, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (XLEN + 5) begin
         @(negedge clk);
         if (wb_we || done) seen = 1'b1;
      end
      check("abort no writeback", 32'(seen), 32'd0);
      run_op("divu 9/3", 2'b01, 32'd9, 32'd3, 5'd14, 0);

      for (int i = 0; i < 150; i++) begin
         run_op($sformatf("rand%0d", i), 2'($urandom), pick_operand(), pick_operand(),
                5'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(2, 25) : 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
